// File: rtl/dec2_steer_ctrl_pkg.sv
// Shared types for the 1-to-2 steering controller: FSM state encoding and target codes.
package dec2_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_e;

   localparam logic TGT_OUT1 = 1'b0;
   localparam logic TGT_OUT2 = 1'b1;

endpackage

// File: rtl/dec2_steer_ctrl_if.sv
// Producer and consumer handshake bundle for dec2_steer_ctrl.
// The slave modport is the steering block's view; master is the surrounding system.
interface dec2_steer_ctrl_if #(
   parameter int unsigned DW = 32
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          sel;
   logic          out1_valid;
   logic          out1_ready;
   logic [DW-1:0] out1_data;
   logic          out2_valid;
   logic          out2_ready;
   logic [DW-1:0] out2_data;

   modport slave (
      input  in_valid, in_data, sel, out1_ready, out2_ready,
      output in_ready, out1_valid, out1_data, out2_valid, out2_data
   );

   modport master (
      output in_valid, in_data, sel, out1_ready, out2_ready,
      input  in_ready, out1_valid, out1_data, out2_valid, out2_data
   );

endinterface

// File: rtl/dec2_steer_ctrl_hold_reg.sv
// One-entry valid/ready holding register: load wins over consume, clear wins over both.
module dec2_hold_reg #(
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          consume,
   input  logic          clear,
   input  logic [DW-1:0] load_data,
   output logic          valid,
   output logic [DW-1:0] data
);

   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (clear) begin
         // Data is deliberately kept; only the valid flag is dropped.
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end else if (consume) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/dec2_steer_ctrl.sv
// Registered 1-to-2 word steering controller with explicit or round-robin targeting and mode-change drain.
// Optional per-destination saturating counters when DEC2_STEER_STATS_EN is defined.
module dec2_steer_ctrl
   import dec2_pkg::*;
#(
   parameter int unsigned DW = 32
`ifdef DEC2_STEER_STATS_EN
   , parameter int unsigned CNT_W = 16
`endif
) (
   input  logic                clk,
   input  logic                rst_n,
   dec2_steer_ctrl_if.slave    io,
   input  logic                mode_alt,
   input  logic                flush,
   output logic                busy
`ifdef DEC2_STEER_STATS_EN
   , output logic [CNT_W-1:0]  out1_cnt
   , output logic [CNT_W-1:0]  out2_cnt
`endif
);

   state_e state_q, state_d;
   logic   mode_q, mode_d;
   logic   rr_q, rr_d;
   logic   tgt, tgt_free, run_ok, in_ready, accept, load1, load2;

   assign tgt      = mode_q ? rr_q : io.sel;
   assign tgt_free = (tgt == TGT_OUT2) ? (!io.out2_valid || io.out2_ready)
                                       : (!io.out1_valid || io.out1_ready);
   // A pending mode change blocks acceptance in the same cycle it is seen.
   assign run_ok   = (state_q == RUN) && (mode_alt == mode_q) && !flush;
   assign in_ready = run_ok && tgt_free;
   assign accept   = io.in_valid && in_ready;
   assign load1    = accept && (tgt == TGT_OUT1);
   assign load2    = accept && (tgt == TGT_OUT2);

   assign io.in_ready = in_ready;

   dec2_hold_reg #(.DW(DW)) u_hold1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load1),
      .consume   (io.out1_ready),
      .clear     (flush),
      .load_data (io.in_data),
      .valid     (io.out1_valid),
      .data      (io.out1_data)
   );

   dec2_hold_reg #(.DW(DW)) u_hold2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load2),
      .consume   (io.out2_ready),
      .clear     (flush),
      .load_data (io.in_data),
      .valid     (io.out2_valid),
      .data      (io.out2_data)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      rr_d    = rr_q;
      case (state_q)
         RUN: begin
            if (mode_alt != mode_q) state_d = DRAIN;
            if (accept && mode_q)   rr_d    = ~rr_q;
         end
         DRAIN: begin
            if (!io.out1_valid && !io.out2_valid) begin
               state_d = RUN;
               mode_d  = mode_alt;
               rr_d    = 1'b0;
            end
         end
         default: state_d = RUN;
      endcase
      if (flush) rr_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         mode_q  <= 1'b0;
         rr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         rr_q    <= rr_d;
      end
   end

   assign busy = (state_q == DRAIN) || io.out1_valid || io.out2_valid;

`ifdef DEC2_STEER_STATS_EN
   logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;

   always_comb begin
      cnt1_d = cnt1_q;
      cnt2_d = cnt2_q;
      if (load1 && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
      if (load2 && (cnt2_q != '1)) cnt2_d = cnt2_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt1_q <= '0;
         cnt2_q <= '0;
      end else begin
         cnt1_q <= cnt1_d;
         cnt2_q <= cnt2_d;
      end
   end

   assign out1_cnt = cnt1_q;
   assign out2_cnt = cnt2_q;
`endif

endmodule

// File: tb/tb_dec2_steer_ctrl.sv
// Bench for dec2_steer_ctrl: directed scenarios then random traffic, checked against a queue-based model.
module tb_dec2_steer_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   logic mode_alt;
   logic flush;
   logic busy;
`ifdef DEC2_STEER_STATS_EN
   logic [15:0] out1_cnt, out2_cnt;
`endif

   always #5 clk = ~clk;

   dec2_steer_ctrl_if #(.DW(32)) io ();

   dec2_steer_ctrl #(
      .DW (32)
`ifdef DEC2_STEER_STATS_EN
      , .CNT_W (16)
`endif
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .io       (io),
      .mode_alt (mode_alt),
      .flush    (flush),
      .busy     (busy)
`ifdef DEC2_STEER_STATS_EN
      , .out1_cnt (out1_cnt)
      , .out2_cnt (out2_cnt)
`endif
   );

   int checks   = 0;
   int failures = 0;

   // Model: each destination is a queue of at most one word, plus mode/pointer/drain flags.
   logic [31:0] q1[$];
   logic [31:0] q2[$];
   bit          m_mode, m_rr, m_drain;
   int unsigned m_c1, m_c2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q1.delete();
      q2.delete();
      m_mode  = 1'b0;
      m_rr    = 1'b0;
      m_drain = 1'b0;
      m_c1    = 0;
      m_c2    = 0;
   endtask

   task automatic drive(input bit v, input logic [31:0] d, input bit s, input bit r1, input bit r2);
      io.in_valid   = v;
      io.in_data    = d;
      io.sel        = s;
      io.out1_ready = r1;
      io.out2_ready = r2;
   endtask

   // Called at a falling edge with inputs set; returns at the next falling edge.
   task automatic step();
      bit   tgt, exp_rdy, acc, empty_now;
      int   tsz;
      logic trdy;
      #1;
      tgt     = m_mode ? m_rr : io.sel;
      tsz     = tgt ? q2.size() : q1.size();
      trdy    = tgt ? io.out2_ready : io.out1_ready;
      exp_rdy = !m_drain && (mode_alt == m_mode) && !flush && (tsz == 0 || trdy);
      acc     = io.in_valid && exp_rdy;
      chk("in_ready", io.in_ready, exp_rdy);
      chk("out1_valid", io.out1_valid, q1.size() != 0);
      chk("out2_valid", io.out2_valid, q2.size() != 0);
      if (q1.size() != 0) chk("out1_data", io.out1_data, q1[0]);
      if (q2.size() != 0) chk("out2_data", io.out2_data, q2[0]);
      chk("busy", busy, m_drain || q1.size() != 0 || q2.size() != 0);
`ifdef DEC2_STEER_STATS_EN
      chk("out1_cnt", {16'b0, out1_cnt}, (m_c1 > 65535) ? 32'hFFFF : m_c1);
      chk("out2_cnt", {16'b0, out2_cnt}, (m_c2 > 65535) ? 32'hFFFF : m_c2);
`endif
      @(posedge clk);
      empty_now = (q1.size() == 0) && (q2.size() == 0);
      if (flush) begin
         q1.delete();
         q2.delete();
      end else begin
         if (q1.size() != 0 && io.out1_ready) void'(q1.pop_front());
         if (q2.size() != 0 && io.out2_ready) void'(q2.pop_front());
         if (acc) begin
            if (tgt) q2.push_back(io.in_data);
            else     q1.push_back(io.in_data);
         end
      end
      if (acc) begin
         if (tgt) m_c2++;
         else     m_c1++;
      end
      if (flush)               m_rr = 1'b0;
      else if (acc && m_mode)  m_rr = ~m_rr;
      if (m_drain) begin
         if (empty_now) begin
            m_drain = 1'b0;
            m_mode  = mode_alt;
            m_rr    = 1'b0;
         end
      end else if (mode_alt != m_mode) begin
         m_drain = 1'b1;
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n    = 1'b0;
      mode_alt = 1'b0;
      flush    = 1'b0;
      drive(0, 32'h0, 0, 0, 0);
      model_reset();
      #12;
      chk("rst_out1_valid", io.out1_valid, 1'b0);
      chk("rst_out2_valid", io.out2_valid, 1'b0);
      chk("rst_out1_data", io.out1_data, 32'h0);
      chk("rst_out2_data", io.out2_data, 32'h0);
      chk("rst_busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Explicit steering
      drive(1, 32'hAAAA0001, 0, 1, 1); step();
      chk("expl_out1_data", io.out1_data, 32'hAAAA0001);
      drive(1, 32'hBBBB0002, 1, 1, 1); step();
      chk("expl_out2_data", io.out2_data, 32'hBBBB0002);
      drive(0, 32'h0, 0, 1, 1); step();

      // Backpressure hold and pass-through replace
      drive(1, 32'h11110001, 0, 0, 0); step();
      drive(1, 32'h11110002, 0, 0, 0); step(); step(); step();
      chk("bp_held", io.out1_data, 32'h11110001);
      drive(1, 32'h11110002, 0, 1, 0); step();
      chk("bp_replace", io.out1_data, 32'h11110002);
      drive(0, 32'h0, 0, 1, 1); step();

      // Alternation, including strict stall on a full target
      mode_alt = 1'b1;
      step(); step();
      drive(1, 32'h1, 1, 1, 0); step();
      drive(1, 32'h2, 0, 1, 0); step();
      drive(1, 32'h3, 1, 1, 0); step();
      drive(1, 32'h4, 0, 1, 0); step(); step(); step();
      drive(1, 32'h4, 0, 1, 1); step();
      chk("alt_out2_4", io.out2_data, 32'h4);
      drive(0, 32'h0, 0, 1, 1); step();

      // Mode-change drain, toggling back mid-drain
      drive(1, 32'hC0DE0001, 0, 0, 0); step();
      drive(1, 32'hC0DE0002, 0, 0, 0); step();
      mode_alt = 1'b0;
      drive(1, 32'hC0DE0003, 0, 0, 0); step(); step();
      mode_alt = 1'b1;
      step();
      drive(1, 32'hC0DE0003, 1, 1, 0); step(); step();
      drive(1, 32'hC0DE0003, 1, 1, 1); step(); step(); step();
      chk("drain_rr0_out1", io.out1_data, 32'hC0DE0003);
      drive(0, 32'h0, 0, 1, 1); step();

      // Flush with both full, then async reset during a stall
      drive(1, 32'hF0000001, 0, 0, 0); step();
      drive(1, 32'hF0000002, 0, 0, 0); step();
      flush = 1'b1;
      drive(1, 32'hF0000003, 0, 0, 0); step();
      flush = 1'b0;
      chk("flush_v1", io.out1_valid, 1'b0);
      drive(1, 32'hF0000004, 0, 0, 0); step();
      drive(1, 32'hF0000005, 0, 0, 0); step();
      drive(1, 32'hF0000006, 0, 0, 0); step();
      #3 rst_n = 1'b0;
      #1;
      chk("arst_out1_valid", io.out1_valid, 1'b0);
      chk("arst_out2_valid", io.out2_valid, 1'b0);
      chk("arst_busy", busy, 1'b0);
      model_reset();
      mode_alt = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Per-side accept counts after reset: 5 to out1, 3 to out2
      for (int i = 0; i < 8; i++) begin
         drive(1, 32'hD0000000 + i, (i >= 5), 1, 1); step();
      end
      drive(0, 32'h0, 0, 1, 1); step();

      // Random traffic with occasional mode changes and flushes
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 29) == 0) mode_alt = ~mode_alt;
         flush = ($urandom_range(0, 24) == 0);
         drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1),
               $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
         step();
      end
      flush = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
